// File: rtl/repl_policy_array.sv
// repl_policy_array: per-set replacement state array (true-LRU, tree-PLRU, round-robin)
// with a self-timed init walk, valid/ready requests and a one-cycle victim response.

module repl_policy_array #(
    parameter int ASSOC      = 8,
    parameter int INDEX_SIZE = 7,
    parameter int POLICY     = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output logic                     init_done,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [1:0]               req_op,
    input  logic [INDEX_SIZE-1:0]    req_index,
    input  logic [$clog2(ASSOC)-1:0] req_way,
    input  logic [ASSOC-1:0]         valid_mask,
    output logic                     rsp_valid,
    output logic [$clog2(ASSOC)-1:0] rsp_victim,
    output logic                     rsp_victim_invalid
);

    localparam int WW    = $clog2(ASSOC);
    localparam int NODES = ASSOC - 1;
    localparam int SW    = ASSOC * WW;

    localparam logic [1:0] OP_LOOKUP = 2'b00;
    localparam logic [1:0] OP_TOUCH  = 2'b01;
    localparam logic [1:0] OP_FILL   = 2'b10;
    localparam logic [1:0] OP_INVAL  = 2'b11;

    localparam logic [WW-1:0] AGE_MAX = WW'(ASSOC - 1);

    if (ASSOC < 2 || (ASSOC & (ASSOC - 1)) != 0) begin : g_bad_assoc
        $error("repl_policy_array: ASSOC must be a power of 2 and >= 2");
    end
    if (POLICY < 0 || POLICY > 2) begin : g_bad_policy
        $error("repl_policy_array: POLICY must be 0, 1 or 2");
    end

    typedef enum logic {
        S_INIT,
        S_RUN
    } fsm_t;

    fsm_t                  fsm;
    logic [INDEX_SIZE-1:0] init_cnt;

    // One state word per set, wide enough for LRU ages;
    // PLRU uses the low ASSOC-1 bits, RR the low WW bits.
    logic [SW-1:0] state_q [1 << INDEX_SIZE];

    logic [SW-1:0] rd;
    logic [SW-1:0] nxt;
    logic [SW-1:0] init_val;
    logic [SW-1:0] wr_data;
    logic [INDEX_SIZE-1:0] wr_idx;
    logic          wr_en;
    logic          accept;

    logic op_update;
    logic op_fill;
    logic op_inval;

    assign rd     = state_q[req_index];
    assign accept = req_valid && req_ready;

    // Decode the request opcode into update / fill / invalidate flags
    always_comb begin
        op_update = 1'b0;
        op_fill   = 1'b0;
        op_inval  = 1'b0;
        unique case (req_op)
            OP_LOOKUP: ;
            OP_TOUCH:  op_update = 1'b1;
            OP_FILL: begin
                op_update = 1'b1;
                op_fill   = 1'b1;
            end
            OP_INVAL: begin
                op_update = 1'b1;
                op_inval  = 1'b1;
            end
        endcase
    end

    // ---------------- true-LRU ages ----------------
    logic [WW-1:0]    age [ASSOC];
    logic [WW-1:0]    age_w;
    logic [ASSOC-1:0] lru_hit;
    logic [SW-1:0]    lru_nxt;
    logic [SW-1:0]    lru_init;
    logic [WW-1:0]    lru_vic;

    assign age_w = age[req_way];

    for (genvar g = 0; g < ASSOC; g++) begin : g_age
        localparam logic [WW-1:0] WAY = WW'(g);
        logic          sel;
        logic [WW-1:0] aged;
        logic [WW-1:0] younger;

        assign age[g]  = rd[g*WW +: WW];
        assign sel     = (req_way == WAY);
        assign lru_hit[g] = (age[g] == AGE_MAX);
        assign lru_init[g*WW +: WW] = WAY;

        // Touch/fill: ways younger than the target age by one.
        // Invalidate: ways older than the target get one step younger.
        assign aged    = (age[g] < age_w) ? age[g] + WW'(1) : age[g];
        assign younger = (age[g] > age_w) ? age[g] - WW'(1) : age[g];

        assign lru_nxt[g*WW +: WW] =
            sel      ? (op_inval ? AGE_MAX : '0) :
            op_inval ? younger : aged;
    end

    // ---------------- tree-PLRU ----------------
    // Heap layout: node 0 is the root; level l holds nodes
    // (2**l)-1 .. (2**(l+1))-2, indexed by the top l bits of the way.
    logic [NODES-1:0] tree;
    logic [NODES-1:0] plru_tnxt;
    logic [ASSOC-1:0] plru_hit;
    logic [SW-1:0]    plru_nxt;
    logic [WW-1:0]    plru_vic;

    assign tree = rd[NODES-1:0];

    for (genvar l = 0; l < WW; l++) begin : g_lvl
        for (genvar p = 0; p < (1 << l); p++) begin : g_node
            localparam int N = (1 << l) - 1 + p;
            logic on_path;
            logic dir;

            assign on_path = ((req_way >> (WW - l)) == WW'(p));
            assign dir     = req_way[WW-1-l];

            // Touch/fill point away from the way, invalidate toward it
            assign plru_tnxt[N] = on_path ? (op_inval ? dir : ~dir) : tree[N];
        end
    end

    // A way is the PLRU victim when every node on its path points to it
    for (genvar w = 0; w < ASSOC; w++) begin : g_pway
        logic [WW-1:0] match;
        for (genvar l = 0; l < WW; l++) begin : g_pl
            localparam int   N = (1 << l) - 1 + (w >> (WW - l));
            localparam logic B = ((w >> (WW - 1 - l)) & 1) != 0;
            assign match[l] = (tree[N] == B);
        end
        assign plru_hit[w] = &match;
    end

    assign plru_nxt = {{(SW - NODES){1'b0}}, plru_tnxt};

    // ---------------- round-robin ----------------
    logic [WW-1:0] rr_ptr;
    logic [SW-1:0] rr_nxt;

    assign rr_ptr = rd[WW-1:0];
    assign rr_nxt = {rd[SW-1:WW], op_fill ? rr_ptr + WW'(1) : rr_ptr};

    // ---------------- victim selection ----------------
    logic [ASSOC-1:0] inv_bits;
    logic [ASSOC-1:0] inv_oh;
    logic             inv_hit;
    logic [WW-1:0]    inv_way;
    logic [WW-1:0]    pol_vic;
    logic [WW-1:0]    victim;

    // Lowest clear bit of valid_mask as a one-hot vector
    assign inv_bits = ~valid_mask;
    assign inv_oh   = inv_bits & (~inv_bits + ASSOC'(1));
    assign inv_hit  = |inv_bits;

    // One-hot to binary for the invalid, LRU and PLRU hit vectors
    for (genvar b = 0; b < WW; b++) begin : g_enc
        logic [ASSOC-1:0] bit_sel;
        for (genvar j = 0; j < ASSOC; j++) begin : g_j
            assign bit_sel[j] = ((j >> b) & 1) != 0;
        end
        assign inv_way[b]  = |(inv_oh & bit_sel);
        assign lru_vic[b]  = |(lru_hit & bit_sel);
        assign plru_vic[b] = |(plru_hit & bit_sel);
    end

    // Pick victim, next state and init value of the configured policy
    always_comb begin
        pol_vic  = rr_ptr;
        nxt      = rr_nxt;
        init_val = '0;
        case (POLICY)
            0: begin
                pol_vic  = lru_vic;
                nxt      = lru_nxt;
                init_val = lru_init;
            end
            1: begin
                pol_vic = plru_vic;
                nxt     = plru_nxt;
            end
            default: ;
        endcase
    end

    assign victim = inv_hit ? inv_way : pol_vic;

    // ---------------- state array write port ----------------
    assign wr_en   = (fsm == S_INIT) || (accept && op_update);
    assign wr_idx  = (fsm == S_INIT) ? init_cnt : req_index;
    assign wr_data = (fsm == S_INIT) ? init_val : nxt;

    // Commit init-walk and request updates; nothing is written in reset
    always_ff @(posedge clk) begin
        if (rst_n && wr_en) begin
            state_q[wr_idx] <= wr_data;
        end
    end

    // Control FSM: init walk over all sets, then accept one request per cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm                <= S_INIT;
            init_cnt           <= '0;
            init_done          <= 1'b0;
            req_ready          <= 1'b0;
            rsp_valid          <= 1'b0;
            rsp_victim         <= '0;
            rsp_victim_invalid <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            unique case (fsm)
                S_INIT: begin
                    init_cnt <= init_cnt + INDEX_SIZE'(1);
                    if (init_cnt == '1) begin
                        fsm       <= S_RUN;
                        init_done <= 1'b1;
                        req_ready <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        rsp_valid          <= 1'b1;
                        rsp_victim         <= victim;
                        rsp_victim_invalid <= inv_hit;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_repl_policy_array.sv
// tb_repl_policy_array: three instances (LRU, PLRU, RR) with ASSOC=4, INDEX_SIZE=2,
// table-driven requests and a response scoreboard.

module tb_repl_policy_array;

    localparam int A  = 4;
    localparam int IX = 2;

    localparam int L = 0;
    localparam int T = 1;
    localparam int F = 2;
    localparam int I = 3;

    typedef struct {
        int         dut;
        logic [1:0] op;
        logic [1:0] idx;
        logic [1:0] way;
        logic [3:0] mask;
        logic [1:0] vic;
        logic       inv;
    } vec_t;

    typedef struct {
        int         dut;
        logic [1:0] vic;
        logic       inv;
        int         id;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] req_v;
    logic [1:0] op;
    logic [1:0] idx;
    logic [1:0] way;
    logic [3:0] mask;
    logic [2:0] done;
    logic [2:0] rdy;
    logic [2:0] rv;
    logic [2:0] rinv;
    logic [1:0] rvic [3];

    int applied = 0;
    int miscompares = 0;
    int vec_id = 0;

    vec_t vt[$];
    exp_t sb[$];

    repl_policy_array #(.ASSOC(A), .INDEX_SIZE(IX), .POLICY(0)) u_lru (
        .clk(clk), .rst_n(rst_n), .init_done(done[0]),
        .req_valid(req_v[0]), .req_ready(rdy[0]), .req_op(op),
        .req_index(idx), .req_way(way), .valid_mask(mask),
        .rsp_valid(rv[0]), .rsp_victim(rvic[0]), .rsp_victim_invalid(rinv[0])
    );

    repl_policy_array #(.ASSOC(A), .INDEX_SIZE(IX), .POLICY(1)) u_plru (
        .clk(clk), .rst_n(rst_n), .init_done(done[1]),
        .req_valid(req_v[1]), .req_ready(rdy[1]), .req_op(op),
        .req_index(idx), .req_way(way), .valid_mask(mask),
        .rsp_valid(rv[1]), .rsp_victim(rvic[1]), .rsp_victim_invalid(rinv[1])
    );

    repl_policy_array #(.ASSOC(A), .INDEX_SIZE(IX), .POLICY(2)) u_rr (
        .clk(clk), .rst_n(rst_n), .init_done(done[2]),
        .req_valid(req_v[2]), .req_ready(rdy[2]), .req_op(op),
        .req_index(idx), .req_way(way), .valid_mask(mask),
        .rsp_valid(rv[2]), .rsp_victim(rvic[2]), .rsp_victim_invalid(rinv[2])
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        applied++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic add(input int d, input int o, input int i, input int w,
                       input int m, input int v, input int n);
        vec_t x;
        x.dut  = d;
        x.op   = 2'(o);
        x.idx  = 2'(i);
        x.way  = 2'(w);
        x.mask = 4'(m);
        x.vic  = 2'(v);
        x.inv  = 1'(n);
        vt.push_back(x);
    endtask

    // Drive one request for one cycle and queue its expected response
    task automatic drive(input vec_t v);
        exp_t e;
        req_v          = 3'b000;
        req_v[v.dut]   = 1'b1;
        op             = v.op;
        idx            = v.idx;
        way            = v.way;
        mask           = v.mask;
        e.dut          = v.dut;
        e.vic          = v.vic;
        e.inv          = v.inv;
        e.id           = vec_id;
        vec_id++;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_init(input string tag);
        int n;
        n = 0;
        check({tag, "_ready_low"}, int'(rdy), 0);
        while (rdy[0] !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_init_cycles"}, n, 4);
        check({tag, "_ready"}, int'(rdy), 7);
        check({tag, "_init_done"}, int'(done), 7);
    endtask

    // Scoreboard: every rsp_valid pulse must match the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 3; d++) begin
            if (rv[d] === 1'b1) begin
                if (sb.size() == 0) begin
                    applied++;
                    miscompares++;
                    $display("FAIL unexpected_rsp dut%0d: got rsp_valid 1, expected 0", d);
                end else begin
                    e = sb.pop_front();
                    check($sformatf("rsp_dut_v%0d", e.id), d, e.dut);
                    check($sformatf("victim_v%0d", e.id), int'(rvic[d]), int'(e.vic));
                    check($sformatf("invalid_v%0d", e.id), int'(rinv[d]), int'(e.inv));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;

        // LRU (instance 0)
        add(0, L, 2, 0, 'hF,    3, 0);
        add(0, T, 1, 3, 'hF,    3, 0);
        add(0, L, 1, 0, 'hF,    2, 0);
        add(0, I, 1, 0, 'hF,    2, 0);
        add(0, L, 1, 0, 'hF,    0, 0);
        add(0, L, 1, 0, 'b1011, 2, 1);
        add(0, L, 1, 0, 'hF,    0, 0);
        add(0, L, 1, 0, 'b0000, 0, 1);
        add(0, L, 1, 0, 'b0111, 3, 1);
        add(0, L, 2, 0, 'hF,    3, 0);
        add(0, F, 3, 1, 'b1101, 1, 1);
        add(0, L, 3, 0, 'hF,    3, 0);
        add(0, T, 3, 3, 'hF,    3, 0);
        add(0, L, 3, 0, 'hF,    2, 0);
        add(0, I, 3, 2, 'hF,    2, 0);
        add(0, L, 3, 0, 'hF,    2, 0);
        // PLRU (instance 1)
        add(1, L, 0, 0, 'hF,    0, 0);
        add(1, T, 0, 0, 'hF,    0, 0);
        add(1, T, 0, 2, 'hF,    2, 0);
        add(1, L, 0, 0, 'hF,    1, 0);
        add(1, I, 0, 3, 'hF,    1, 0);
        add(1, L, 0, 0, 'hF,    3, 0);
        add(1, F, 0, 3, 'hF,    3, 0);
        add(1, L, 0, 0, 'hF,    1, 0);
        add(1, L, 1, 0, 'hF,    0, 0);
        add(1, L, 0, 0, 'b1110, 0, 1);
        // Round-robin (instance 2)
        add(2, F, 0, 0, 'hF,    0, 0);
        add(2, F, 0, 1, 'hF,    1, 0);
        add(2, F, 0, 2, 'hF,    2, 0);
        add(2, F, 0, 3, 'hF,    3, 0);
        add(2, F, 0, 0, 'hF,    0, 0);
        add(2, L, 1, 0, 'hF,    0, 0);
        add(2, L, 0, 0, 'hF,    1, 0);
        add(2, T, 0, 2, 'hF,    1, 0);
        add(2, I, 0, 2, 'hF,    1, 0);
        add(2, L, 0, 0, 'hF,    1, 0);
        add(2, F, 0, 0, 'b0111, 3, 1);
        add(2, L, 0, 0, 'hF,    2, 0);

        req_v = 3'b000;
        op    = 2'b00;
        idx   = 2'b00;
        way   = 2'b00;
        mask  = 4'hF;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_init_done", int'(done), 0);
        check("rst_req_ready", int'(rdy), 0);
        check("rst_rsp_valid", int'(rv), 0);
        check("rst_invalid", int'(rinv), 0);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("rst_victim_dut%0d", d), int'(rvic[d]), 0);
        end

        rst_n = 1'b1;
        wait_init("boot");

        for (int k = 0; k < vt.size(); k++) begin
            drive(vt[k]);
        end
        req_v = 3'b000;
        @(posedge clk);
        #1;

        // Reset with a touch held valid: no response, no update
        req_v = 3'b001;
        op    = 2'(T);
        idx   = 2'd1;
        way   = 2'd0;
        mask  = 4'hF;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_rsp_valid", int'(rv), 0);
        check("midrst_init_done", int'(done), 0);
        rst_n = 1'b1;
        req_v = 3'b000;
        wait_init("reinit");

        v = '{dut: 0, op: 2'(L), idx: 2'd1, way: 2'd0, mask: 4'hF, vic: 2'd3, inv: 1'b0};
        drive(v);
        v = '{dut: 1, op: 2'(L), idx: 2'd0, way: 2'd0, mask: 4'hF, vic: 2'd0, inv: 1'b0};
        drive(v);
        v = '{dut: 2, op: 2'(L), idx: 2'd0, way: 2'd0, mask: 4'hF, vic: 2'd0, inv: 1'b0};
        drive(v);
        req_v = 3'b000;

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
